// File: rtl/bitmap_margin_scan.sv
// Multi-cycle empty-margin finder for a ROWS x COLS glyph bitmap: one row per cycle, then one column per cycle.
// Optional set-pixel counter is built when the PIXCNT_EN macro is defined.
module bitmap_margin_scan #(
    parameter int ROWS = 64,
    parameter int COLS = 24
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wren,
    input  logic [ROWS*COLS-1:0]             bitmap,
    output logic                             busy,
    output logic                             done,
    output logic                             nonempty,
    output logic [$clog2(ROWS+1)-1:0]        top,
    output logic [$clog2(ROWS+1)-1:0]        bottom,
    output logic [$clog2(COLS+1)-1:0]        left,
    output logic [$clog2(COLS+1)-1:0]        right,
    output logic [$clog2(ROWS*COLS+1)-1:0]   pixel_count
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS + 1);
    localparam int CW = $clog2(COLS + 1);
    localparam int PW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ROWSCAN, COLSCAN, DONE} state_t;

    state_t            state;
    logic [RW-1:0]     row_idx;
    logic [CW-1:0]     col_idx;
    logic [N-1:0]      bm_q;
    logic [COLS-1:0]   col_occ;
    logic [RW-1:0]     first_row;
    logic [RW-1:0]     last_row;
    logic [CW-1:0]     first_col;
    logic [CW-1:0]     last_col;
    logic              found_row;
    logic              found_col;
    logic [COLS-1:0]   cur_row;
    logic              row_hit;
    logic              col_hit;
    logic              accept;
    logic              col_step;

`ifdef PIXCNT_EN
    logic [PW-1:0]     pix_acc;

    function automatic logic [PW-1:0] popcount(input logic [COLS-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++)
            n = n + PW'(v[i]);
        return n;
    endfunction
`endif

    // The latched bitmap shifts up one row per cycle, so the current row is always the top slice.
    assign cur_row  = bm_q[N-1 -: COLS];
    assign row_hit  = |cur_row;
    assign col_hit  = col_occ[COLS-1];
    assign accept   = wren && (state == IDLE || state == DONE);
    assign col_step = (state == COLSCAN) && (col_idx != CW'(COLS));

    // Datapath: latched bitmap, column occupancy and hit trackers are cleared on accept instead of reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            bm_q      <= bitmap;
            col_occ   <= '0;
            found_row <= 1'b0;
            found_col <= 1'b0;
`ifdef PIXCNT_EN
            pix_acc   <= '0;
`endif
        end else if (state == ROWSCAN) begin
            bm_q    <= bm_q << COLS;
            col_occ <= col_occ | cur_row;
`ifdef PIXCNT_EN
            pix_acc <= pix_acc + popcount(cur_row);
`endif
            if (row_hit) begin
                if (!found_row)
                    first_row <= row_idx;
                found_row <= 1'b1;
                last_row  <= row_idx;
            end
        end else if (col_step) begin
            col_occ <= col_occ << 1;
            if (col_hit) begin
                if (!found_col)
                    first_col <= col_idx;
                found_col <= 1'b1;
                last_col  <= col_idx;
            end
        end
    end

    // Control FSM and registered results; the extra COLSCAN cycle at col_idx==COLS commits results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            row_idx     <= '0;
            col_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            nonempty    <= 1'b0;
            top         <= '0;
            bottom      <= '0;
            left        <= '0;
            right       <= '0;
            pixel_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (wren) begin
                        state   <= ROWSCAN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        row_idx <= '0;
                        col_idx <= '0;
                    end
                end
                ROWSCAN: begin
                    row_idx <= row_idx + RW'(1);
                    if (row_idx == RW'(ROWS - 1))
                        state <= COLSCAN;
                end
                COLSCAN: begin
                    if (col_idx == CW'(COLS)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        nonempty <= found_row;
                        top      <= found_row ? first_row : RW'(ROWS);
                        bottom   <= found_row ? (RW'(ROWS - 1) - last_row) : RW'(ROWS);
                        left     <= found_col ? first_col : CW'(COLS);
                        right    <= found_col ? (CW'(COLS - 1) - last_col) : CW'(COLS);
`ifdef PIXCNT_EN
                        pixel_count <= pix_acc;
`endif
                    end else begin
                        col_idx <= col_idx + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitmap_margin_scan.sv
// Bench for bitmap_margin_scan: table vectors, multi-cycle corner sequences and randomized bitmaps vs. a reference model.
module tb_bitmap_margin_scan;

    localparam int ROWS = 64;
    localparam int COLS = 24;
    localparam int N    = ROWS * COLS;
    localparam int RW   = $clog2(ROWS + 1);
    localparam int CW   = $clog2(COLS + 1);
    localparam int PW   = $clog2(N + 1);
    localparam int LAT  = ROWS + COLS + 1;
    localparam int SN   = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wren = 1'b0;
    logic [N-1:0]  bitmap = '0;
    logic          busy, done, nonempty;
    logic [RW-1:0] top, bottom;
    logic [CW-1:0] left, right;
    logic [PW-1:0] pixel_count;

    logic          wren8 = 1'b0;
    logic [SN-1:0] bitmap8 = '0;
    logic          busy8, done8, nonempty8;
    logic [3:0]    top8, bottom8, left8, right8;
    logic [6:0]    pixel_count8;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [N-1:0] bm;
        int nonempty;
        int top;
        int bottom;
        int left;
        int right;
        int pix;
    } vec_t;

    bitmap_margin_scan #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .wren(wren), .bitmap(bitmap),
        .busy(busy), .done(done), .nonempty(nonempty),
        .top(top), .bottom(bottom), .left(left), .right(right),
        .pixel_count(pixel_count)
    );

    bitmap_margin_scan #(.ROWS(8), .COLS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .wren(wren8), .bitmap(bitmap8),
        .busy(busy8), .done(done8), .nonempty(nonempty8),
        .top(top8), .bottom(bottom8), .left(left8), .right(right8),
        .pixel_count(pixel_count8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] set_row(input logic [N-1:0] bm, input int r, input logic [COLS-1:0] v);
        logic [N-1:0] b;
        b = bm;
        b[(ROWS-r)*COLS-1 -: COLS] = v;
        return b;
    endfunction

    // Reference: scan every pixel, keep min/max row and column plus a count.
    function automatic vec_t model(input logic [N-1:0] bm);
        vec_t e;
        int rmin, rmax, cmin, cmax, cnt;
        rmin = ROWS; rmax = -1; cmin = COLS; cmax = -1; cnt = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (bm[(ROWS-r)*COLS-1-c]) begin
                    cnt++;
                    if (r < rmin) rmin = r;
                    if (r > rmax) rmax = r;
                    if (c < cmin) cmin = c;
                    if (c > cmax) cmax = c;
                end
        e.bm       = bm;
        e.nonempty = (cnt > 0) ? 1 : 0;
        e.top      = (cnt > 0) ? rmin : ROWS;
        e.bottom   = (cnt > 0) ? ROWS - 1 - rmax : ROWS;
        e.left     = (cnt > 0) ? cmin : COLS;
        e.right    = (cnt > 0) ? COLS - 1 - cmax : COLS;
`ifdef PIXCNT_EN
        e.pix      = cnt;
`else
        e.pix      = 0;
`endif
        return e;
    endfunction

    task automatic check_result(input string tag, input vec_t e);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".nonempty"}, nonempty, e.nonempty);
        check({tag, ".top"}, top, e.top);
        check({tag, ".bottom"}, bottom, e.bottom);
        check({tag, ".left"}, left, e.left);
        check({tag, ".right"}, right, e.right);
        check({tag, ".pixel_count"}, pixel_count, e.pix);
    endtask

    // Pulse wren for one edge, scramble the input afterwards, then count edges until done (bounded).
    task automatic run_scan(input string tag, input vec_t e);
        int n;
        @(negedge clk);
        bitmap = e.bm;
        wren   = 1'b1;
        @(negedge clk);
        wren   = 1'b0;
        bitmap = ~e.bm;
        check({tag, ".busy_after_accept"}, busy, 1);
        check({tag, ".done_cleared"}, done, 0);
        n = 0;
        while (!done && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, n, LAT);
        check_result(tag, e);
    endtask

    vec_t         tbl[5];
    vec_t         e, ea, eb;
    logic [N-1:0] bm;
    int           n;

    initial begin
        bm = '0;
        for (int r = 35; r <= 61; r++) bm = set_row(bm, r, 24'h3f0000);
`ifdef PIXCNT_EN
        tbl[0] = '{bm, 1, 35, 2, 2, 16, 162};
        tbl[3] = '{'1, 1, 0, 0, 0, 0, N};
        bm = '0; bm[N-24] = 1'b1;
        tbl[2] = '{bm, 1, 0, 63, 23, 0, 1};
        bm = '0; bm[COLS-1] = 1'b1;
        tbl[4] = '{bm, 1, 63, 0, 0, 23, 1};
`else
        tbl[0] = '{bm, 1, 35, 2, 2, 16, 0};
        tbl[3] = '{'1, 1, 0, 0, 0, 0, 0};
        bm = '0; bm[N-24] = 1'b1;
        tbl[2] = '{bm, 1, 0, 63, 23, 0, 0};
        bm = '0; bm[COLS-1] = 1'b1;
        tbl[4] = '{bm, 1, 63, 0, 0, 23, 0};
`endif
        tbl[1] = '{'0, 0, 64, 64, 24, 24, 0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.nonempty", nonempty, 0);
        check("rst.top", top, 0);
        check("rst.bottom", bottom, 0);
        check("rst.left", left, 0);
        check("rst.right", right, 0);
        check("rst.pixel_count", pixel_count, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_scan($sformatf("tbl%0d", i), tbl[i]);

        // DONE holds without wren
        repeat (5) @(negedge clk);
        check("hold.done", done, 1);
        check("hold.top", top, tbl[4].top);
        check("hold.right", right, tbl[4].right);

        // wren during a scan is ignored
        ea = tbl[0];
        eb = tbl[2];
        @(negedge clk);
        bitmap = ea.bm;
        wren   = 1'b1;
        @(negedge clk);
        wren   = 1'b0;
        n = 0;
        while (!done && n < 4 * LAT) begin
            if (n == 10) begin
                bitmap = eb.bm;
                wren   = 1'b1;
            end else begin
                wren   = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        wren = 1'b0;
        check("rewren.latency", n, LAT);
        check_result("rewren", ea);

        // Asynchronous reset mid-scan
        @(negedge clk);
        bitmap = tbl[3].bm;
        wren   = 1'b1;
        @(negedge clk);
        wren   = 1'b0;
        repeat (39) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.nonempty", nonempty, 0);
        check("abort.top", top, 0);
        check("abort.left", left, 0);
        check("abort.pixel_count", pixel_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 5) @(negedge clk);
        check("abort.no_done", done, 0);
        run_scan("after_abort", tbl[0]);

        // Randomized bitmaps against the model
        for (int t = 0; t < 24; t++) begin
            int mode;
            bm = '0;
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                for (int k = $urandom_range(1, 4); k > 0; k--)
                    bm[$urandom_range(0, N-1)] = 1'b1;
            end else if (mode == 1) begin
                int r0, r1, c0, c1;
                r0 = $urandom_range(0, ROWS-1); r1 = $urandom_range(r0, ROWS-1);
                c0 = $urandom_range(0, COLS-1); c1 = $urandom_range(c0, COLS-1);
                for (int r = r0; r <= r1; r++)
                    for (int c = c0; c <= c1; c++)
                        bm[(ROWS-r)*COLS-1-c] = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                for (int w = 0; w < N / 32; w++)
                    bm[w*32 +: 32] = $urandom & $urandom;
            end
            run_scan($sformatf("rand%0d", t), model(bm));
        end

        // 8x8 full bitmap
        @(negedge clk);
        bitmap8 = '1;
        wren8   = 1'b1;
        @(negedge clk);
        wren8   = 1'b0;
        bitmap8 = '0;
        n = 0;
        while (!done8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("small.latency", n, 17);
        check("small.nonempty", nonempty8, 1);
        check("small.top", top8, 0);
        check("small.bottom", bottom8, 0);
        check("small.left", left8, 0);
        check("small.right", right8, 0);
`ifdef PIXCNT_EN
        check("small.pixel_count", pixel_count8, 64);
`else
        check("small.pixel_count", pixel_count8, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
